// File: rtl/reg_op_if.sv
// reg_op_if: command handshake from producer plus drive lines to the operation register
// master: producer side (drives cmd_*), slave: sequencer side (drives cmd_ready, A, selector, busy, done, err)
interface reg_op_if #(
  parameter int DATA_W = 5,
  parameter int CNT_W = 3
);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [DATA_W-1:0] A;
  logic [4:0] selector;
  logic busy;
  logic done;
  logic err;
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input cmd_ready, A, selector, busy, done, err
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, A, selector, busy, done, err
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: FIFO-buffered command stage issuing one register operation per clk, expanding multi-step shifts
// ports: clk, rst (async active-high); bus (reg_op_if.slave): cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_count in, A/selector/busy/done/err out
module reg_op_sequencer #(
  parameter int DATA_W = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  reg_op_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + DATA_W + CNT_W;
  typedef enum logic [1:0] {IDLE, ISSUE, REPEAT} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic en, empty, full, push, pop, shift, free;
  logic [2:0] h_op;
  logic [DATA_W-1:0] h_data, a_n;
  logic [CNT_W-1:0] h_cnt, h_rem, rem, rem_n;
  logic [4:0] sel_n;
  logic done_n, err_n;
  assign empty = wp == rp;
  assign full = (wp - rp) == (AW + 1)'(DEPTH);
  // en keeps cmd_ready low until the first posedge after reset release
  assign bus.cmd_ready = en && !full;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign {h_op, h_data, h_cnt} = mem[rp[AW-1:0]];
  assign h_rem = (h_cnt == '0) ? '0 : h_cnt - 1'b1;
  assign shift = h_op == 3'd2 || h_op == 3'd3;
  assign bus.busy = state != IDLE || !empty;
  // the current cycle ends a command (or is idle/dropped), so the head may issue next
  assign free = state == IDLE || bus.done || bus.err;
  always_comb begin
    state_n = state;
    sel_n = bus.selector;
    a_n = bus.A;
    done_n = 1'b0;
    err_n = 1'b0;
    rem_n = rem;
    pop = 1'b0;
    if (free) begin
      pop = !empty;
      sel_n = '0;
      state_n = pop ? ISSUE : IDLE;
      if (pop && h_op > 3'd4) err_n = 1'b1;
      else if (pop) begin
        sel_n = 5'(h_op);
        a_n = (h_op == 3'd1) ? h_data : bus.A;
        rem_n = shift ? h_rem : '0;
        state_n = (shift && h_rem != '0) ? REPEAT : ISSUE;
        done_n = !(shift && h_rem != '0);
      end
    end else begin
      rem_n = rem - 1'b1;
      done_n = rem == CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      bus.selector <= '0;
      bus.A <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      en <= 1'b0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      bus.selector <= sel_n;
      bus.A <= a_n;
      bus.done <= done_n;
      bus.err <= err_n;
      en <= 1'b1;
      wp <= wp + (AW + 1)'(push);
      rp <= rp + (AW + 1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= {bus.cmd_op, bus.cmd_data, bus.cmd_count};
  end
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: directed and random checks of reg_op_sequencer against a command-expansion model
module tb_reg_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  reg_op_if #(.DATA_W(5), .CNT_W(3)) bus();
  reg_op_sequencer #(.DATA_W(5), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  typedef struct packed {logic [2:0] op; logic [4:0] data; logic [2:0] cnt;} cmd_t;
  typedef struct packed {logic [4:0] sel; logic ld; logic [4:0] data; logic dn; logic er; logic act;} step_t;
  cmd_t q[$];
  step_t expq[$];
  step_t cur;
  int total = 0;
  int bad = 0;
  logic m_en, last_push;
  logic [4:0] m_a, m_reg, t_reg;
  function automatic logic [4:0] reg_next(logic [4:0] r, logic [4:0] s, logic [4:0] a);
    return s == 5'd1 ? a : s == 5'd2 ? r >> 1 : s == 5'd3 ? r << 1 : s == 5'd4 ? 5'd0 : r;
  endfunction
  always @(negedge clk or posedge rst) begin
    if (rst) t_reg <= 5'd0;
    else t_reg <= reg_next(t_reg, bus.selector, bus.A);
  end
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask
  task automatic expand(input cmd_t c);
    int n;
    if (c.op > 3'd4) expq.push_back('{5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1});
    else if (c.op == 3'd2 || c.op == 3'd3) begin
      n = (c.cnt == 3'd0) ? 1 : int'(c.cnt);
      for (int i = 0; i < n; i++) expq.push_back('{5'(c.op), 1'b0, 5'd0, i == n - 1, 1'b0, 1'b1});
    end else expq.push_back('{5'(c.op), c.op == 3'd1, c.data, 1'b1, 1'b0, 1'b1});
  endtask
  task automatic tick();
    logic push;
    chk("ready", 8'(bus.cmd_ready), 8'(m_en && q.size() < 4));
    push = bus.cmd_valid && m_en && q.size() < 4;
    @(posedge clk);
    if (expq.size() == 0 && q.size() > 0) expand(q.pop_front());
    cur = (expq.size() > 0) ? expq.pop_front() : '0;
    if (cur.ld) m_a = cur.data;
    if (push) q.push_back('{bus.cmd_op, bus.cmd_data, bus.cmd_count});
    m_en = 1'b1;
    last_push = push;
    #1;
    chk("selector", 8'(bus.selector), 8'(cur.sel));
    chk("A", 8'(bus.A), 8'(m_a));
    chk("done", 8'(bus.done), 8'(cur.dn));
    chk("err", 8'(bus.err), 8'(cur.er));
    chk("busy", 8'(bus.busy), 8'(cur.act || q.size() > 0));
    chk("regout", 8'(t_reg), 8'(m_reg));
    m_reg = reg_next(m_reg, cur.sel, m_a);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    q.delete();
    expq.delete();
    m_en = 1'b0;
    m_a = 5'd0;
    m_reg = 5'd0;
    last_push = 1'b0;
    #1;
    chk("rst_selector", 8'(bus.selector), 8'd0);
    chk("rst_A", 8'(bus.A), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_err", 8'(bus.err), 8'd0);
    chk("rst_ready", 8'(bus.cmd_ready), 8'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic send(input logic [2:0] op, input logic [4:0] data, input logic [2:0] cnt);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_data = data;
    bus.cmd_count = cnt;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_push) break;
    end
    chk("accepted", 8'(last_push), 8'd1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_data = 5'd0;
    bus.cmd_count = 3'd0;
    do_reset();
    idle(1);
    send(3'd1, 5'h13, 3'd0);
    send(3'd2, 5'h00, 3'd2);
    chk("t1_sel_load", 8'(bus.selector), 8'd1);
    chk("t1_done_load", 8'(bus.done), 8'd1);
    idle(1);
    chk("t1_sel_sh1", 8'(bus.selector), 8'd2);
    chk("t1_done_sh1", 8'(bus.done), 8'd0);
    chk("t1_reg_13", 8'(t_reg), 8'h13);
    idle(1);
    chk("t1_sel_sh2", 8'(bus.selector), 8'd2);
    chk("t1_done_sh2", 8'(bus.done), 8'd1);
    chk("t1_reg_09", 8'(t_reg), 8'h09);
    idle(1);
    chk("t1_sel_hold", 8'(bus.selector), 8'd0);
    chk("t1_reg_04", 8'(t_reg), 8'h04);
    send(3'd1, 5'h05, 3'd0);
    send(3'd3, 5'h00, 3'd0);
    idle(1);
    chk("t2_sel_shl", 8'(bus.selector), 8'd3);
    chk("t2_done_shl", 8'(bus.done), 8'd1);
    idle(1);
    chk("t2_sel_hold", 8'(bus.selector), 8'd0);
    chk("t2_reg_0a", 8'(t_reg), 8'h0A);
    idle(2);
    send(3'd3, 5'h00, 3'd7);
    for (int i = 0; i < 5; i++) send(3'd1, 5'($urandom_range(0, 31)), 3'd0);
    idle(12);
    chk("t3_idle_busy", 8'(bus.busy), 8'd0);
    send(3'd6, 5'h00, 3'd0);
    send(3'd4, 5'h00, 3'd0);
    chk("t4_err", 8'(bus.err), 8'd1);
    chk("t4_sel_err", 8'(bus.selector), 8'd0);
    idle(1);
    chk("t4_sel_clr", 8'(bus.selector), 8'd4);
    chk("t4_done_clr", 8'(bus.done), 8'd1);
    idle(1);
    chk("t4_busy", 8'(bus.busy), 8'd0);
    send(3'd1, 5'h0A, 3'd0);
    send(3'd3, 5'h00, 3'd3);
    send(3'd1, 5'h1F, 3'd0);
    idle(1);
    chk("t5_sel_sh2", 8'(bus.selector), 8'd3);
    do_reset();
    idle(5);
    chk("t5_no_issue", 8'(bus.selector), 8'd0);
    send(3'd1, 5'h01, 3'd0);
    idle(1);
    chk("t6_sel_load", 8'(bus.selector), 8'd1);
    chk("t6_done", 8'(bus.done), 8'd1);
    idle(1);
    chk("t6_sel_hold", 8'(bus.selector), 8'd0);
    chk("t6_done_low", 8'(bus.done), 8'd0);
    for (int i = 0; i < 400; i++) begin
      if (!(bus.cmd_valid && !last_push)) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op = 3'($urandom_range(0, 7));
        bus.cmd_data = 5'($urandom_range(0, 31));
        bus.cmd_count = 3'($urandom_range(0, 7));
      end
      tick();
      if (i == 200) begin
        do_reset();
        idle(1);
      end
    end
    idle(80);
    chk("final_busy", 8'(bus.busy), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
